// File: rtl/des_pkg.sv
// -----------------------------------------------------------------------------
// des_pkg
// Shared DES key-schedule constants and types.
//   ROUNDS / CD_W / SK_W : fixed DES geometry (16 rounds, 28-bit halves,
//                          48-bit subkeys)
//   LAST_CNT             : round counter value of the final subkey
//   state_t              : key-schedule controller states
//   PC1_TBL              : permuted choice 1, 1-based key bit per CD position
//                          (entries 0..27 build C, 28..55 build D)
//   SHIFT_TBL            : left-rotation amount per round, index 0 = round 1
// -----------------------------------------------------------------------------
package des_pkg;

    localparam int ROUNDS = 16;
    localparam int CD_W   = 28;
    localparam int SK_W   = 48;

    localparam logic [3:0] LAST_CNT = 4'(ROUNDS - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [6:0] PC1_TBL [56] = '{
        7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,
        7'd1,  7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18,
        7'd10, 7'd2,  7'd59, 7'd51, 7'd43, 7'd35, 7'd27,
        7'd19, 7'd11, 7'd3,  7'd60, 7'd52, 7'd44, 7'd36,
        7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15,
        7'd7,  7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22,
        7'd14, 7'd6,  7'd61, 7'd53, 7'd45, 7'd37, 7'd29,
        7'd21, 7'd13, 7'd5,  7'd28, 7'd20, 7'd12, 7'd4
    };

    localparam logic [1:0] SHIFT_TBL [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

endpackage

// File: rtl/des_pc1.sv
// -----------------------------------------------------------------------------
// des_pc1
// Permuted choice 1: selects the 56 non-parity key bits and splits them into
// the C and D halves. Purely combinational.
//   key : [1:64] DES key, bit 1 = MSB (parity bits 8,16,..,64 unused)
//   c   : C0 half, MSB = first C bit
//   d   : D0 half, MSB = first D bit
// -----------------------------------------------------------------------------
module des_pc1
    import des_pkg::*;
(
    input  logic [1:64]     key,
    output logic [CD_W-1:0] c,
    output logic [CD_W-1:0] d
);

    // Table-driven bit gather into the two halves
    always_comb begin
        c = '0;
        d = '0;
        for (int i = 0; i < CD_W; i++) begin
            c[CD_W-1-i] = key[PC1_TBL[i]];
            d[CD_W-1-i] = key[PC1_TBL[i+CD_W]];
        end
    end

endmodule

// File: rtl/des_pc2.sv
// -----------------------------------------------------------------------------
// des_pc2
// Permuted choice 2: compresses the 56-bit {C,D} state into a 48-bit round
// subkey. Purely combinational.
//   cd : [1:56] concatenated C and D, bit 1 = MSB of C
//   sk : [1:48] round subkey, bit 1 = MSB
// -----------------------------------------------------------------------------
module des_pc2
    import des_pkg::*;
(
    input  logic [1:56]   cd,
    output logic [1:SK_W] sk
);

    localparam logic [5:0] PC2_TBL [48] = '{
        6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
        6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
        6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
        6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
        6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
        6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
        6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
        6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
    };

    // Table-driven bit gather from the CD state
    always_comb begin
        sk = '0;
        for (int i = 0; i < SK_W; i++) begin
            sk[i+1] = cd[PC2_TBL[i]];
        end
    end

endmodule

// File: rtl/des_key_schedule.sv
// -----------------------------------------------------------------------------
// des_key_schedule
// Sequential DES subkey generator. Loads a 64-bit key on start and streams the
// 16 round subkeys over a valid/ready handshake: K1..K16 when encrypting,
// K16..K1 when decrypting (right-rotation schedule).
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : load key and begin a schedule (only when ready=1)
//   decrypt    : sampled with start; 0 = K1..K16, 1 = K16..K1
//   key        : [1:64] DES key, bit 1 = MSB
//   ready      : idle, able to accept start
//   sk_valid   : sk_data holds a valid subkey
//   sk_ready   : consumer accepts the current subkey
//   sk_data    : [1:48] current subkey
//   sk_round   : K-number minus 1 of the current subkey
//   sk_last    : current subkey is the final one of the schedule
//   done       : one-cycle pulse after the final subkey is accepted
// -----------------------------------------------------------------------------
module des_key_schedule
    import des_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          decrypt,
    input  logic [1:64]   key,
    output logic          ready,
    output logic          sk_valid,
    input  logic          sk_ready,
    output logic [1:SK_W] sk_data,
    output logic [3:0]    sk_round,
    output logic          sk_last,
    output logic          done
);

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    state_t          state_r;
    logic [CD_W-1:0] c_r;
    logic [CD_W-1:0] d_r;
    logic [3:0]      cnt_r;
    logic            mode_r;
    logic            ready_r;
    logic            sk_valid_r;
    logic [3:0]      sk_round_r;
    logic            sk_last_r;
    logic            done_r;

    logic [CD_W-1:0] pc1_c_s;
    logic [CD_W-1:0] pc1_d_s;
    logic [3:0]      shift_idx_s;
    logic [1:0]      shift_amt_s;

    // Rotate a 28-bit half by 1 or 2 places; bits wrap within the half.
    function automatic logic [CD_W-1:0] rot28(
        input logic [CD_W-1:0] x,
        input logic [1:0]      amt,
        input logic            dir
    );
        logic [CD_W-1:0] r;
        case ({dir, amt})
            3'b0_01: r = {x[CD_W-2:0], x[CD_W-1]};
            3'b0_10: r = {x[CD_W-3:0], x[CD_W-1:CD_W-2]};
            3'b1_01: r = {x[0], x[CD_W-1:1]};
            3'b1_10: r = {x[1:0], x[CD_W-1:2]};
            default: r = x;
        endcase
        return r;
    endfunction

    des_pc1 u_pc1 (
        .key (key),
        .c   (pc1_c_s),
        .d   (pc1_d_s)
    );

    des_pc2 u_pc2 (
        .cd  ({c_r, d_r}),
        .sk  (sk_data)
    );

    // Rotation amount for the step taken when the current subkey is accepted.
    // Encrypt advances to round cnt+2 (table index cnt+1); decrypt undoes the
    // left shift that produced the current round (table index 15-cnt).
    always_comb begin
        shift_idx_s = 4'd0;
        if (mode_r) begin
            shift_idx_s = LAST_CNT - cnt_r;
        end else begin
            shift_idx_s = cnt_r + 4'd1;
        end
        shift_amt_s = SHIFT_TBL[shift_idx_s];
    end

    // Controller: load, step and retire the schedule; all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            c_r        <= '0;
            d_r        <= '0;
            cnt_r      <= 4'd0;
            mode_r     <= 1'b0;
            ready_r    <= 1'b1;
            sk_valid_r <= 1'b0;
            sk_round_r <= 4'd0;
            sk_last_r  <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        // Decrypt starts from the unrotated halves: C0/D0 equal
                        // C16/D16 because the total left shift is 28.
                        if (decrypt) begin
                            c_r        <= pc1_c_s;
                            d_r        <= pc1_d_s;
                            sk_round_r <= LAST_CNT;
                        end else begin
                            c_r        <= rot28(pc1_c_s, 2'd1, DIR_LEFT);
                            d_r        <= rot28(pc1_d_s, 2'd1, DIR_LEFT);
                            sk_round_r <= 4'd0;
                        end
                        mode_r     <= decrypt;
                        cnt_r      <= 4'd0;
                        state_r    <= RUN;
                        ready_r    <= 1'b0;
                        sk_valid_r <= 1'b1;
                        sk_last_r  <= 1'b0;
                    end
                end
                RUN: begin
                    done_r <= 1'b0;
                    if (sk_ready) begin
                        if (cnt_r == LAST_CNT) begin
                            state_r    <= IDLE;
                            sk_valid_r <= 1'b0;
                            ready_r    <= 1'b1;
                            sk_last_r  <= 1'b0;
                            done_r     <= 1'b1;
                        end else begin
                            cnt_r     <= cnt_r + 4'd1;
                            c_r       <= rot28(c_r, shift_amt_s, mode_r ? DIR_RIGHT : DIR_LEFT);
                            d_r       <= rot28(d_r, shift_amt_s, mode_r ? DIR_RIGHT : DIR_LEFT);
                            sk_last_r <= (cnt_r == (LAST_CNT - 4'd1));
                            if (mode_r) begin
                                sk_round_r <= (LAST_CNT - 4'd1) - cnt_r;
                            end else begin
                                sk_round_r <= cnt_r + 4'd1;
                            end
                        end
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    ready_r    <= 1'b1;
                    sk_valid_r <= 1'b0;
                    sk_last_r  <= 1'b0;
                    done_r     <= 1'b0;
                end
            endcase
        end
    end

    assign ready    = ready_r;
    assign sk_valid = sk_valid_r;
    assign sk_round = sk_round_r;
    assign sk_last  = sk_last_r;
    assign done     = done_r;

endmodule

// File: doc/des_key_schedule.md
Name: des_key_schedule

Overview:
Sequential DES subkey generator. It takes a 64-bit key and emits the 16 round subkeys one per handshake: K1..K16 for encryption, or K16..K1 for decryption (right-rotation schedule). It sits between the key register and the round datapath and streams subkeys to the round engine. It instantiates the existing PC2 block for compression.

Parameters:
none (DES fixed: 16 rounds, 56-bit CD, 48-bit subkey)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  load key and begin a schedule; accepted only when ready=1
- decrypt  input  1  sampled with start; 0 = K1→K16, 1 = K16→K1
- key  input  [1:64]  DES key, bit 1 = MSB; parity bits 8,16,…,64 ignored
- ready  output  1  high in IDLE; start accepted when start&ready
- sk_valid  output  1  subkey on sk_data is valid
- sk_ready  input  1  consumer accepts subkey when sk_valid&sk_ready
- sk_data  output  [1:48]  current subkey, bit 1 = MSB
- sk_round  output  4  index of the emitted subkey, 0..15 = K1..K16 (K-number minus 1)
- sk_last  output  1  high with the 16th subkey of the schedule
- done  output  1  one-cycle pulse on the cycle after the 16th subkey is accepted

Behaviour:
- Reset (async, rst_n=0): state IDLE, ready=1, sk_valid=0, sk_round=0, sk_last=0, done=0, C/D registers=0, counter=0, mode=0. Release is synchronous to clk.
- State IDLE:
  - start&ready at edge t: C,D ← PC1(key) halves (28 bits each); mode ← decrypt; cnt ← 0.
  - Encrypt: C,D are additionally rotated left by 1 in the same load, because shift for round 1 is 1.
  - Next state RUN. ready=0 and sk_valid=1 from t+1, so latency from start to first subkey is 1 cycle.
- State RUN: sk_data = PC2({C,D}), combinational from registers.
  - Encrypt: sk_round = cnt.
  - Decrypt: sk_round = 15−cnt.
  - Decrypt round 1 uses the PC1 halves unrotated, which equal C16/D16.
- On sk_valid&sk_ready with cnt<15: cnt ← cnt+1, then rotate C and D:
  - Encrypt: left by SHIFT[cnt+1].
  - Decrypt: right by SHIFT[15−cnt].
  - SHIFT[0..15] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- sk_last = (cnt==15) while in RUN. On accept with cnt==15 → IDLE, sk_valid←0, ready←1, done←1 for one cycle.
- Backpressure: while sk_valid&!sk_ready, sk_data, sk_round, sk_last and C/D hold stable. There is no combinational path from sk_ready to sk_valid.
- start while ready=0 is ignored; key and decrypt are not sampled.
- start in the same cycle that done is asserted: accepted, because ready=1 then. A back-to-back schedule gives a 1-cycle gap between the last and first sk_valid.
- Asserting rst_n low mid-schedule aborts immediately to reset values; no partial state survives.
- The 28-bit rotations wrap within each half; C and D never exchange bits.
- Decrypt consistency: the total right-rotation over 15 steps is 27 per half, matching encrypt C2..C16 in reverse.

Decomposition:
- Package des_pkg holds:
  - the PC1 index table
  - the SHIFT table (16×2-bit)
  - ROUNDS=16, CD_W=28, SK_W=48
  - a state enum {IDLE, RUN}
- Sub-modules:
  - PC2: the existing combinational block, instantiated once on {C,D}.
  - PC1: a small combinational sub-module.
- Rotation: a local function rot28(x, amt, dir).

Test Plan:
- FIPS key 0x133457799BBCDFF1, decrypt=0, sk_ready=1 → first sk_data at t+1 = 0x1B02EFFC7072, sk_round=0; 16th = 0xCB3D8B0E17F5 with sk_last=1; done pulses 1 cycle later.
- Same key, decrypt=1 → first sk_data = 0xCB3D8B0E17F5, sk_round=15; last = 0x1B02EFFC7072, sk_round=0. The full sequence is the exact reverse of the encrypt run, checked against a reference model for all 16 subkeys.
- Random sk_ready toggling (about 50%) → sk_data/sk_round stable while stalled; exactly 16 accepts; sequence identical to the no-stall run.
- start pulsed with key 0xFFFF_FFFF_FFFF_FFFF during RUN → ignored, subkeys still from the original key. Keys 0x0000000000000000 and 0x0101010101010101 (parity-only bits) → all 16 subkeys 0x000000000000.
- rst_n low at round 7 → immediately sk_valid=0, ready=1, sk_round=0. A new start then produces a correct full schedule.
- start asserted in the done cycle → accepted, next schedule's first subkey at the following cycle.
